scaler_ctrl: RTL

Command sequencer for the image-resize datapath. Accepts one resize command (operation, factor), holds all scaler engines in reset except the selected one, and muxes that engine's ROM read address and RAM write address/data onto the shared memories. It detects engine completion, flushes the last write, and reports done, timeout or illegal-command status. It sits between the host/button command logic and the four engines: copy, nearest-neighbour, block averaging and pixel replication.

---
 rtl/scaler_ctrl_if.sv | 10 +
 rtl/scaler_ctrl.sv | 134 +++++++++++++
 2 files changed

// File: rtl/scaler_ctrl_if.sv
// rtl/scaler_ctrl_if.sv - resize command handshake between host logic and scaler_ctrl
interface scaler_ctrl_if;
  logic       cmd_valid;
  logic [1:0] cmd_op;
  logic [2:0] cmd_factor;
  logic       cmd_ready;

  modport master (output cmd_valid, output cmd_op, output cmd_factor, input cmd_ready);
  modport slave  (input cmd_valid, input cmd_op, input cmd_factor, output cmd_ready);
endinterface

// File: rtl/scaler_ctrl.sv
// rtl/scaler_ctrl.sv - resize command sequencer: engine select/reset, memory muxing, status
module scaler_ctrl #(
  parameter int NENG      = 4,
  parameter int CLR_CYC   = 2,
  parameter int FLUSH_CYC = 2,
  parameter int TIMEOUT   = 200000
) (
  input  logic                 clk,
  input  logic                 reset,
  scaler_ctrl_if.slave         cmd,
  output logic [NENG-1:0]      eng_rst_n,
  output logic [2:0]           eng_factor,
  input  logic [NENG-1:0]      eng_done,
  input  logic [19*NENG-1:0]   eng_rom_addr,
  input  logic [19*NENG-1:0]   eng_ram_wraddr,
  input  logic [8*NENG-1:0]    eng_pixel,
  output logic [18:0]          rom_addr,
  output logic [18:0]          ram_wraddr,
  output logic [7:0]           ram_wrdata,
  output logic                 ram_we,
  output logic                 busy,
  output logic                 op_done,
  output logic                 err,
  output logic [1:0]           err_code
);

  typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_RUN, S_FLUSH, S_FIN} state_t;

  localparam logic [23:0] CLR_LAST   = 24'(CLR_CYC - 1);
  localparam logic [23:0] FLUSH_LAST = 24'(FLUSH_CYC - 1);
  localparam logic [23:0] TO_LAST    = 24'(TIMEOUT - 1);

  state_t            state, state_nxt;
  logic [1:0]        sel, sel_nxt;
  logic [23:0]       cnt, cnt_nxt;
  logic [2:0]        factor_nxt;
  logic              err_nxt;
  logic [1:0]        err_code_nxt;
  logic              accept, legal;
  logic              cmd_ready_nxt, busy_nxt, ram_we_nxt, op_done_nxt;
  logic [NENG-1:0]   eng_rst_n_nxt;

  // Gating on the registered ready keeps the first edge after reset from accepting.
  assign accept = (state == S_IDLE) && cmd.cmd_ready && cmd.cmd_valid;
  assign legal  = (cmd.cmd_op == 2'd0) ? (cmd.cmd_factor == 3'd1)
                                       : ((cmd.cmd_factor == 3'd2) || (cmd.cmd_factor == 3'd4));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= S_IDLE;
      sel   <= 2'd0;
      cnt   <= 24'd0;
    end else begin
      state <= state_nxt;
      sel   <= sel_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    sel_nxt      = sel;
    factor_nxt   = eng_factor;
    err_nxt      = err;
    err_code_nxt = err_code;
    case (state)
      S_IDLE: begin
        if (accept) begin
          sel_nxt    = cmd.cmd_op;
          factor_nxt = cmd.cmd_factor;
          if (legal) begin
            state_nxt    = S_CLEAR;
            err_nxt      = 1'b0;
            err_code_nxt = 2'd0;
          end else begin
            err_nxt      = 1'b1;
            err_code_nxt = 2'd1;
          end
        end
      end
      S_CLEAR: if (cnt == CLR_LAST) state_nxt = S_RUN;
      S_RUN: begin
        // Done takes priority over a timeout landing on the same cycle.
        if (eng_done[sel]) begin
          state_nxt = S_FLUSH;
        end else if (cnt == TO_LAST) begin
          state_nxt    = S_IDLE;
          err_nxt      = 1'b1;
          err_code_nxt = 2'd2;
        end
      end
      S_FLUSH: if (cnt == FLUSH_LAST) state_nxt = S_FIN;
      S_FIN:   state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
    cnt_nxt = ((state_nxt != state) || (state == S_IDLE)) ? 24'd0 : cnt + 24'd1;
  end

  always_comb begin
    cmd_ready_nxt = (state_nxt == S_IDLE);
    busy_nxt      = (state_nxt != S_IDLE);
    ram_we_nxt    = (state_nxt == S_RUN) || (state_nxt == S_FLUSH);
    op_done_nxt   = (state_nxt == S_FIN);
    eng_rst_n_nxt = '0;
    if (ram_we_nxt) eng_rst_n_nxt[sel_nxt] = 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cmd.cmd_ready <= 1'b0;
      busy          <= 1'b0;
      ram_we        <= 1'b0;
      op_done       <= 1'b0;
      eng_rst_n     <= '0;
      eng_factor    <= 3'd0;
      err           <= 1'b0;
      err_code      <= 2'd0;
    end else begin
      cmd.cmd_ready <= cmd_ready_nxt;
      busy          <= busy_nxt;
      ram_we        <= ram_we_nxt;
      op_done       <= op_done_nxt;
      eng_rst_n     <= eng_rst_n_nxt;
      eng_factor    <= factor_nxt;
      err           <= err_nxt;
      err_code      <= err_code_nxt;
    end
  end

  assign rom_addr   = eng_rom_addr[19*int'(sel) +: 19];
  assign ram_wraddr = eng_ram_wraddr[19*int'(sel) +: 19];
  assign ram_wrdata = eng_pixel[8*int'(sel) +: 8];

endmodule
